// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_WORD   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Bytes per instruction word, and the width of the lane counter
    localparam int LANES   = 4;
    localparam int LANE_W  = $clog2(LANES);
    localparam int WORD_W  = LANES * 8;

    // Frame checksum is a byte-wide running XOR
    localparam int CSUM_W  = 8;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts stream bytes MSB-first into one instruction word; owns the lane counter.
// Latency: word register updates on the edge of each accepted byte; word_full is combinational with the 4th shift.
// Backpressure: none of its own; the top only asserts shift_i on an accepted byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;

    // Next word/lane: a clear abandons any partial word, a shift appends one byte at the bottom
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clear_i) begin
            word_d = '0;
            lane_d = '0;
        end else if (shift_i) begin
            word_d = {word_q[WORD_W-9:0], byte_i};
            lane_d = lane_q + 1'b1;
        end
    end

    // Word and lane registers
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> 32-bit instruction-memory writes, holds CPU in reset until a good load.
// Latency: write strobe one cycle after a word's 4th byte; done/error one cycle after the checksum byte.
// Backpressure: in_ready low outside CNT_HI/CNT_LO/WORD/CHECK, so every word costs at least 5 cycles.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_din,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;   // word count N from the frame header
    logic [15:0]         wcnt_q, wcnt_d;     // words written so far; 16 bits so N == DEPTH terminates
    logic [CSUM_W-1:0]   xor_q, xor_d;       // running XOR of all frame bytes before the checksum

    logic                xfer;
    logic                start_acc;
    logic                word_full;
    logic [15:0]         n_new;
    logic [WORD_W-1:0]   packed_word;

    assign xfer      = in_valid && in_ready;
    assign start_acc = load_start &&
                       (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign n_new     = {count_q[15:8], in_data};

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_acc),
        .shift_i     (xfer && (state_q == S_WORD)),
        .byte_i      (in_data),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    // Next-state, count capture, word counter and checksum accumulation
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        xor_d   = xor_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_acc) begin
                    state_d = S_CNT_HI;
                    wcnt_d  = '0;
                    xor_d   = '0;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = in_data;
                    xor_d         = xor_q ^ in_data;
                    state_d       = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = in_data;
                    xor_d        = xor_q ^ in_data;
                    if ({1'b0, n_new} > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (n_new == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_WORD;
                    end
                end
            end
            S_WORD: begin
                if (xfer) begin
                    xor_d = xor_q ^ in_data;
                    if (word_full) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wcnt_d  = wcnt_q + 16'd1;
                state_d = (wcnt_d == count_q) ? S_CHECK : S_WORD;
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            wcnt_q  <= '0;
            xor_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            xor_q   <= xor_d;
        end
    end

    // All status outputs decode directly from the state register
    assign in_ready  = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                       (state_q == S_WORD)   || (state_q == S_CHECK);
    assign busy      = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                       (state_q == S_WORD)   || (state_q == S_WRITE)  ||
                       (state_q == S_CHECK);
    assign im_we     = (state_q == S_WRITE);
    assign im_addr   = wcnt_q[AW-1:0];
    assign im_din    = packed_word;
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign cpu_reset = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_din;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    // Write log captured by the monitor
    logic [7:0]  wa [64];
    logic [31:0] wd [64];
    int          nw = 0;
    int          rdy_in_write = 0;

    logic [31:0] frame_w [8];
    logic [7:0]  ref_a [8];
    logic [31:0] ref_d [8];

    imem_loader #(.DEPTH(256), .AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            if (nw < 64) begin
                wa[nw] = im_addr;
                wd[nw] = im_din;
            end
            nw = nw + 1;
            if (in_ready) rdy_in_write = rdy_in_write + 1;
        end
    end

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present one byte; the transfer happens on the first posedge with in_ready high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Start a frame, send count and n words from frame_w; returns the correct checksum.
    task automatic send_body(input int n, input int gapmax, output logic [7:0] csum);
        logic [15:0] cnt;
        logic [7:0]  b;
        cnt  = 16'(n);
        csum = 8'h00;
        pulse_start();
        send_byte(cnt[15:8], 0); csum ^= cnt[15:8];
        send_byte(cnt[7:0], 0);  csum ^= cnt[7:0];
        for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) begin
                b = frame_w[i][k*8 +: 8];
                send_byte(b, (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
                csum ^= b;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({in_ready, im_we, im_addr, im_din, cpu_reset, busy, done, error} !==
            {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%0b we=%0b addr=%h din=%h cpurst=%0b busy=%0b done=%0b err=%0b required 0 0 00 00000000 1 0 0 0",
                     in_ready, im_we, im_addr, im_din, cpu_reset, busy, done, error);
        end
    endtask

    task automatic test_good_load;
        logic [7:0] cs;
        frame_w[0] = 32'h20010005;
        frame_w[1] = 32'h8C220004;
        nw = 0;
        send_body(2, 0, cs);
        n_cmp++;
        if (cs !== 8'h8C) begin
            n_fail++; $display("FAIL good_checksum_model: got %h required 8c", cs);
        end
        n_cmp++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL good_before_csum: cpurst=%0b busy=%0b required 1 1", cpu_reset, busy);
        end
        send_byte(8'h8C, 0);
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_status: done=%0b err=%0b cpurst=%0b busy=%0b required 1 0 0 0", done, error, cpu_reset, busy);
        end
        n_cmp++;
        if (nw !== 2 || wa[0] !== 8'h00 || wd[0] !== 32'h20010005 ||
            wa[1] !== 8'h01 || wd[1] !== 32'h8C220004) begin
            n_fail++;
            $display("FAIL good_writes: n=%0d a0=%h d0=%h a1=%h d1=%h required 2 00 20010005 01 8c220004",
                     nw, wa[0], wd[0], wa[1], wd[1]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            n_fail++; $display("FAIL good_hold: done=%0b cpurst=%0b required 1 0", done, cpu_reset);
        end
    endtask

    task automatic test_bad_checksum;
        logic [7:0] cs;
        frame_w[0] = 32'h20010005;
        frame_w[1] = 32'h8C220004;
        nw = 0;
        send_body(2, 0, cs);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL bad_done_cleared: done=%0b required 0", done);
        end
        send_byte(8'h8D, 0);
        n_cmp++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL bad_status: err=%0b done=%0b cpurst=%0b required 1 0 1", error, done, cpu_reset);
        end
        n_cmp++;
        if (nw !== 2 || wd[0] !== 32'h20010005 || wd[1] !== 32'h8C220004) begin
            n_fail++; $display("FAIL bad_writes: n=%0d d0=%h d1=%h required 2 20010005 8c220004", nw, wd[0], wd[1]);
        end
    endtask

    task automatic test_zero_words;
        nw = 0;
        pulse_start();
        n_cmp++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_start: err=%0b rdy=%0b required 0 1", error, in_ready);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_at_check: done=%0b rdy=%0b required 0 1", done, in_ready);
        end
        send_byte(8'h00, 0);
        n_cmp++;
        if (done !== 1'b1 || nw !== 0 || cpu_reset !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: done=%0b writes=%0d cpurst=%0b required 1 0 0", done, nw, cpu_reset);
        end
    endtask

    task automatic test_overcount;
        nw = 0;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        n_cmp++;
        if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL overcount_err: err=%0b rdy=%0b busy=%0b required 1 0 0", error, in_ready, busy);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || nw !== 0 || error !== 1'b1) begin
            n_fail++; $display("FAIL overcount_hold: rdy=%0b writes=%0d err=%0b required 0 0 1", in_ready, nw, error);
        end
    endtask

    task automatic test_gapped;
        logic [7:0] cs;
        frame_w[0] = 32'h11223344;
        frame_w[1] = 32'hDEADBEEF;
        frame_w[2] = 32'h00000001;
        frame_w[3] = 32'hCAFEF00D;
        nw = 0;
        rdy_in_write = 0;
        send_body(4, 0, cs);
        send_byte(cs, 0);
        for (int i = 0; i < 4; i++) begin
            ref_a[i] = wa[i];
            ref_d[i] = wd[i];
        end
        n_cmp++;
        if (cs !== 8'hAA || done !== 1'b1 || nw !== 4) begin
            n_fail++; $display("FAIL ungapped_run: cs=%h done=%0b writes=%0d required aa 1 4", cs, done, nw);
        end
        nw = 0;
        send_body(4, 3, cs);
        send_byte(cs, 2);
        n_cmp++;
        if (done !== 1'b1 || nw !== 4) begin
            n_fail++; $display("FAIL gapped_run: done=%0b writes=%0d required 1 4", done, nw);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (wa[i] !== 8'(i) || wd[i] !== frame_w[i] || wa[i] !== ref_a[i] || wd[i] !== ref_d[i]) begin
                n_fail++;
                $display("FAIL gapped_write%0d: addr=%h data=%h required %h %h", i, wa[i], wd[i], 8'(i), frame_w[i]);
            end
        end
        n_cmp++;
        if (rdy_in_write !== 0) begin
            n_fail++; $display("FAIL ready_in_write: %0d cycles with in_ready high during im_we, required 0", rdy_in_write);
        end
    endtask

    task automatic test_midframe_reset;
        logic [7:0] cs;
        frame_w[0] = 32'h01020304;
        frame_w[1] = 32'h55667788;
        nw = 0;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int k = 3; k >= 0; k--) send_byte(frame_w[0][k*8 +: 8], 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        n_cmp++;
        if (nw !== 1 || wd[0] !== 32'h01020304) begin
            n_fail++; $display("FAIL prereset_write: writes=%0d d0=%h required 1 01020304", nw, wd[0]);
        end
        test_reset();
        nw = 0;
        frame_w[0] = 32'hA5A50F0F;
        send_body(1, 0, cs);
        send_byte(cs, 0);
        n_cmp++;
        if (nw !== 1 || wa[0] !== 8'h00 || wd[0] !== 32'hA5A50F0F || done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload: writes=%0d a0=%h d0=%h done=%0b required 1 00 a5a50f0f 1", nw, wa[0], wd[0], done);
        end
    endtask

    task automatic test_reset_beats_start;
        reset      = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        load_start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL reset_wins: busy=%0b rdy=%0b done=%0b cpurst=%0b required 0 0 0 1", busy, in_ready, done, cpu_reset);
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_words();
        test_overcount();
        test_gapped();
        test_midframe_reset();
        test_reset_beats_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
